// File: rtl/max_exp_renorm.sv
// max_exp_renorm: turns a signed fixed-point sum aligned to a shared maximum
// exponent back into a normalized FP16 value, rounded to nearest-even.
// Two registered stages with a valid/ready handshake; stage 1 finds sign,
// magnitude and leading-one position, stage 2 normalizes, rounds and
// resolves zero / infinity / flush-to-zero.
module max_exp_renorm #(
  parameter int ACC_W          = 16,
  parameter int FRAC_W         = 10,
  parameter int FP16_exp_width = 5
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_valid,
  output logic                      o_ready,
  input  logic [ACC_W-1:0]          i_sum,
  input  logic [FP16_exp_width:0]   i_max_exp,
  input  logic                      i_zero,
  output logic                      o_valid,
  input  logic                      i_ready,
  output logic [15:0]               o_z,
  output logic [50:0]               number
);

  localparam int MANT_W = 10;
  localparam int P_W    = $clog2(ACC_W);
  // Exponent arithmetic is carried wide enough that neither the largest
  // shared exponent plus leading-one position nor a negative result can wrap.
  localparam int E_W    = FP16_exp_width + P_W + 3;
  localparam logic [E_W-1:0] EXP_INF = E_W'((1 << FP16_exp_width) - 1);
  localparam logic [50:0] GATE_COUNT = 51'd1873;

  // Handshake enables
  logic s2_en;
  logic s1_en;

  // Stage 1 registers
  logic                    s1_valid;
  logic                    s1_sign;
  logic [ACC_W-1:0]        s1_mag;
  logic [P_W-1:0]          s1_p;
  logic [FP16_exp_width:0] s1_exp;
  logic                    s1_zero;

  // Stage 1 combinational values
  logic [ACC_W-1:0] mag_in;
  logic [P_W-1:0]   lead;

  // Stage 2 combinational values
  logic [P_W-1:0]    shift;
  logic [ACC_W-1:0]  norm;
  logic [MANT_W-1:0] mant_raw;
  logic              guard;
  logic              sticky;
  logic              round_up;
  logic [MANT_W:0]   mant_sum;
  logic              carry;
  logic [E_W-1:0]    e_adj;
  logic              underflow;
  logic              overflow;
  logic              is_zero;
  logic [15:0]       z_next;

  // The output stage may advance when it is empty or being drained; the
  // first stage may advance when it is empty or the output stage advances.
  // o_ready therefore depends combinationally on i_ready.
  assign s2_en   = !o_valid || i_ready;
  assign s1_en   = !s1_valid || s2_en;
  assign o_ready = s1_en;
  assign number  = GATE_COUNT;

  // Two's-complement magnitude; the most negative sum maps to 2^(ACC_W-1),
  // which still fits in ACC_W unsigned bits.
  assign mag_in = i_sum[ACC_W-1] ? (~i_sum + ACC_W'(1)) : i_sum;

  // Leading-one search: the highest set bit wins because it is visited last.
  always_comb begin
    lead = '0;
    for (int i = 0; i < ACC_W; i++) begin
      if (mag_in[i]) lead = P_W'(i);
    end
  end

  // Stage 1: capture sign, magnitude, leading-one position and side info.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s1_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_mag   <= '0;
      s1_p     <= '0;
      s1_exp   <= '0;
      s1_zero  <= 1'b0;
    end else if (s1_en) begin
      s1_valid <= i_valid;
      s1_sign  <= i_sum[ACC_W-1];
      s1_mag   <= mag_in;
      s1_p     <= lead;
      s1_exp   <= i_max_exp;
      s1_zero  <= i_zero;
    end
  end

  // Stage 2 datapath: normalize so the leading one sits in the top bit, take
  // the next MANT_W bits as the fraction, round to nearest-even on the rest,
  // then build the FP16 word with the special cases taking priority.
  always_comb begin
    shift     = P_W'(ACC_W - 1) - s1_p;
    norm      = s1_mag << shift;
    mant_raw  = norm[ACC_W-2 -: MANT_W];
    guard     = norm[ACC_W-2-MANT_W];
    sticky    = |norm[ACC_W-3-MANT_W:0];
    round_up  = guard && (sticky || mant_raw[0]);
    mant_sum  = {1'b0, mant_raw} + (MANT_W+1)'(round_up);
    carry     = mant_sum[MANT_W];
    e_adj     = E_W'(s1_exp) + E_W'(s1_p) - E_W'(FRAC_W) + E_W'(carry);
    underflow = e_adj[E_W-1] || (e_adj == '0);
    overflow  = !e_adj[E_W-1] && (e_adj >= EXP_INF);
    // A zero magnitude leaves no leading one after normalization.
    is_zero   = s1_zero || !norm[ACC_W-1];
    z_next    = {s1_sign, e_adj[FP16_exp_width-1:0], mant_sum[MANT_W-1:0]};
    if (is_zero) begin
      z_next = 16'h0000;
    end else if (overflow) begin
      z_next = {s1_sign, {FP16_exp_width{1'b1}}, {MANT_W{1'b0}}};
    end else if (underflow) begin
      z_next = {s1_sign, {(FP16_exp_width + MANT_W){1'b0}}};
    end
  end

  // Stage 2: register the result; holds stable while downstream stalls.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_valid <= 1'b0;
      o_z     <= 16'h0000;
    end else if (s2_en) begin
      o_valid <= s1_valid;
      if (s1_valid) o_z <= z_next;
    end
  end

endmodule

// File: tb/tb_max_exp_renorm.sv
// Testbench for max_exp_renorm: scoreboard of expected FP16 words pushed on
// input acceptance and popped on output transfer, one task per scenario.
module tb_max_exp_renorm;

  logic        clk;
  logic        i_rst;
  logic        i_valid;
  logic        o_ready;
  logic [15:0] i_sum;
  logic [5:0]  i_max_exp;
  logic        i_zero;
  logic        o_valid;
  logic        i_ready;
  logic [15:0] o_z;
  logic [50:0] number;

  int          checks;
  int          failures;
  logic [15:0] sb[$];
  int          lat_q[$];
  logic [50:0] number_ref;

  max_exp_renorm #(
    .ACC_W(16),
    .FRAC_W(10),
    .FP16_exp_width(5)
  ) dut (
    .i_clk(clk),
    .i_rst(i_rst),
    .i_valid(i_valid),
    .o_ready(o_ready),
    .i_sum(i_sum),
    .i_max_exp(i_max_exp),
    .i_zero(i_zero),
    .o_valid(o_valid),
    .i_ready(i_ready),
    .o_z(o_z),
    .number(number)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  // One cycle: sample handshake outcome on the falling edge, then move to
  // just after the next rising edge so the caller can drive new inputs.
  task automatic tick(output logic acc, output logic emit, output logic [15:0] z,
                      output logic rdy, output logic ov);
    @(negedge clk);
    acc  = i_valid && o_ready;
    emit = o_valid && i_ready;
    z    = o_z;
    rdy  = o_ready;
    ov   = o_valid;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    i_rst   = 1'b1;
    i_valid = 1'b0;
    i_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    i_rst = 1'b0;
    checks++;
    if (o_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_o_valid got=%b expected=0", o_valid);
    end
    checks++;
    if (o_z !== 16'h0000) begin
      failures++;
      $display("[TB] FAIL reset_o_z got=%h expected=0000", o_z);
    end
    checks++;
    if (o_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL reset_o_ready got=%b expected=1", o_ready);
    end
    checks++;
    if (number === 51'd0) begin
      failures++;
      $display("[TB] FAIL reset_number got=%0d expected=nonzero", number);
    end
    number_ref = number;
  endtask

  task automatic test_directed();
    logic [15:0] sums [18];
    logic [5:0]  exps [18];
    logic        zeros[18];
    logic [15:0] want [18];
    logic        acc, emit, rdy, ov;
    logic [15:0] z, exp_z;
    int          idx, t, lat;
    sums  = '{16'h0400, 16'hFA00, 16'h7FFF, 16'h0C03, 16'h0801, 16'h1003,
              16'h1001, 16'h0400, 16'h0400, 16'h7FFF, 16'h0400, 16'hFC00,
              16'h0400, 16'h8000, 16'h1234, 16'h0000, 16'h0003, 16'hFFFF};
    exps  = '{6'd15, 6'd16, 6'd15, 6'd15, 6'd15, 6'd15,
              6'd15, 6'd31, 6'd30, 6'd26, 6'd0,  6'd0,
              6'd1,  6'd15, 6'd20, 6'd15, 6'd15, 6'd25};
    zeros = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
              1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
              1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    want  = '{16'h3C00, 16'hC200, 16'h5000, 16'h4202, 16'h4000, 16'h4401,
              16'h4400, 16'h7C00, 16'h7800, 16'h7C00, 16'h0000, 16'h8000,
              16'h0400, 16'hD000, 16'h0000, 16'h0000, 16'h1A00, 16'hBC00};
    idx = 0;
    t   = 0;
    i_ready = 1'b1;
    sb.delete();
    lat_q.delete();
    while ((idx < 18 || sb.size() > 0) && t < 200) begin
      if (idx < 18) begin
        i_valid   = 1'b1;
        i_sum     = sums[idx];
        i_max_exp = exps[idx];
        i_zero    = zeros[idx];
      end else begin
        i_valid = 1'b0;
      end
      tick(acc, emit, z, rdy, ov);
      if (emit) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("[TB] FAIL directed_extra got=%h expected=none", z);
        end else begin
          exp_z = sb.pop_front();
          lat   = t - lat_q.pop_front();
          if (z !== exp_z) begin
            failures++;
            $display("[TB] FAIL directed_value got=%h expected=%h", z, exp_z);
          end
          checks++;
          if (lat != 2) begin
            failures++;
            $display("[TB] FAIL directed_latency got=%0d expected=2", lat);
          end
        end
      end
      if (acc) begin
        sb.push_back(want[idx]);
        lat_q.push_back(t);
        idx++;
      end
      t++;
    end
    i_valid = 1'b0;
    i_zero  = 1'b0;
    checks++;
    if (idx != 18 || sb.size() != 0) begin
      failures++;
      $display("[TB] FAIL directed_timeout got=%0d_sent_%0d_pending expected=18_sent_0_pending",
               idx, sb.size());
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] sums [3];
    logic [15:0] want [3];
    logic        acc, emit, rdy, ov;
    logic [15:0] z, exp_z;
    int          idx, t, first_out, last_out, n_out;
    sums = '{16'h0400, 16'h0800, 16'h0C00};
    want = '{16'h3C00, 16'h4000, 16'h4200};
    idx  = 0;
    sb.delete();
    i_ready   = 1'b0;
    i_max_exp = 6'd15;
    i_zero    = 1'b0;
    for (int c = 0; c < 5; c++) begin
      i_valid = 1'b1;
      i_sum   = sums[idx];
      tick(acc, emit, z, rdy, ov);
      if (acc) begin
        sb.push_back(want[idx]);
        idx++;
      end
      checks++;
      if (c < 2) begin
        if (acc !== 1'b1) begin
          failures++;
          $display("[TB] FAIL bp_accept got=%b expected=1", acc);
        end
      end else begin
        if (rdy !== 1'b0 || ov !== 1'b1 || z !== 16'h3C00) begin
          failures++;
          $display("[TB] FAIL bp_hold got=rdy%b_ov%b_z%h expected=rdy0_ov1_z3c00", rdy, ov, z);
        end
      end
    end
    i_ready   = 1'b1;
    t         = 0;
    first_out = -1;
    last_out  = -1;
    n_out     = 0;
    while ((idx < 3 || sb.size() > 0) && t < 20) begin
      if (idx < 3) begin
        i_valid = 1'b1;
        i_sum   = sums[idx];
      end else begin
        i_valid = 1'b0;
      end
      tick(acc, emit, z, rdy, ov);
      if (emit) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("[TB] FAIL bp_extra got=%h expected=none", z);
        end else begin
          exp_z = sb.pop_front();
          if (z !== exp_z) begin
            failures++;
            $display("[TB] FAIL bp_order got=%h expected=%h", z, exp_z);
          end
        end
        if (first_out < 0) first_out = t;
        last_out = t;
        n_out++;
      end
      if (acc) begin
        sb.push_back(want[idx]);
        idx++;
      end
      t++;
    end
    i_valid = 1'b0;
    checks++;
    if (n_out != 3 || (last_out - first_out) != 2) begin
      failures++;
      $display("[TB] FAIL bp_drain got=%0d_outputs_span_%0d expected=3_outputs_span_2",
               n_out, last_out - first_out);
    end
  endtask

  task automatic test_back_to_back();
    logic        acc, emit, rdy, ov;
    logic [15:0] z, exp_z;
    logic [15:0] want [8];
    int          idx, t, first_out, last_out, n_out, not_ready;
    want = '{16'h3C00, 16'h4000, 16'h4200, 16'h4400,
             16'h4500, 16'h4600, 16'h4700, 16'h4800};
    idx       = 0;
    t         = 0;
    first_out = -1;
    last_out  = -1;
    n_out     = 0;
    not_ready = 0;
    sb.delete();
    i_ready   = 1'b1;
    i_max_exp = 6'd15;
    i_zero    = 1'b0;
    while ((idx < 8 || sb.size() > 0) && t < 40) begin
      if (idx < 8) begin
        i_valid = 1'b1;
        i_sum   = 16'((idx + 1) * 1024);
      end else begin
        i_valid = 1'b0;
      end
      tick(acc, emit, z, rdy, ov);
      if (i_valid && !rdy) not_ready++;
      if (emit) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("[TB] FAIL b2b_extra got=%h expected=none", z);
        end else begin
          exp_z = sb.pop_front();
          if (z !== exp_z) begin
            failures++;
            $display("[TB] FAIL b2b_value got=%h expected=%h", z, exp_z);
          end
        end
        if (first_out < 0) first_out = t;
        last_out = t;
        n_out++;
      end
      if (acc) begin
        sb.push_back(want[idx]);
        idx++;
      end
      t++;
    end
    i_valid = 1'b0;
    checks++;
    if (not_ready != 0) begin
      failures++;
      $display("[TB] FAIL b2b_ready got=%0d_stalled_cycles expected=0", not_ready);
    end
    checks++;
    if (n_out != 8 || first_out != 2 || last_out != 9) begin
      failures++;
      $display("[TB] FAIL b2b_stream got=%0d_outputs_first_%0d_last_%0d expected=8_outputs_first_2_last_9",
               n_out, first_out, last_out);
    end
  endtask

  task automatic test_reset_mid();
    logic        acc, emit, rdy, ov;
    logic [15:0] z, exp_z;
    sb.delete();
    i_ready   = 1'b1;
    i_max_exp = 6'd15;
    i_zero    = 1'b0;
    i_valid   = 1'b1;
    i_sum     = 16'h0C00;
    tick(acc, emit, z, rdy, ov);
    if (acc) sb.push_back(16'h4200);
    i_sum = 16'h1000;
    tick(acc, emit, z, rdy, ov);
    if (acc) sb.push_back(16'h4400);
    i_valid = 1'b0;
    i_rst   = 1'b1;
    tick(acc, emit, z, rdy, ov);
    i_rst = 1'b0;
    sb.delete();
    checks++;
    if (o_valid !== 1'b0 || o_z !== 16'h0000) begin
      failures++;
      $display("[TB] FAIL rst_mid_clear got=ov%b_z%h expected=ov0_z0000", o_valid, o_z);
    end
    i_valid = 1'b1;
    i_sum   = 16'h0800;
    tick(acc, emit, z, rdy, ov);
    if (acc) sb.push_back(16'h4000);
    checks++;
    if (acc !== 1'b1) begin
      failures++;
      $display("[TB] FAIL rst_mid_accept got=%b expected=1", acc);
    end
    i_valid = 1'b0;
    tick(acc, emit, z, rdy, ov);
    checks++;
    if (ov !== 1'b0) begin
      failures++;
      $display("[TB] FAIL rst_mid_stale got=ov%b_z%h expected=ov0", ov, z);
    end
    tick(acc, emit, z, rdy, ov);
    checks++;
    if (emit !== 1'b1 || sb.size() == 0) begin
      failures++;
      $display("[TB] FAIL rst_mid_latency got=emit%b expected=emit1", emit);
    end else begin
      exp_z = sb.pop_front();
      if (z !== exp_z) begin
        failures++;
        $display("[TB] FAIL rst_mid_value got=%h expected=%h", z, exp_z);
      end
    end
    for (int c = 0; c < 3; c++) begin
      tick(acc, emit, z, rdy, ov);
      checks++;
      if (ov !== 1'b0) begin
        failures++;
        $display("[TB] FAIL rst_mid_extra got=ov%b_z%h expected=ov0", ov, z);
      end
    end
  endtask

  task automatic test_number();
    checks++;
    if (number !== number_ref) begin
      failures++;
      $display("[TB] FAIL number_stable got=%0d expected=%0d", number, number_ref);
    end
  endtask

  // Scenario sequence
  initial begin
    clk       = 1'b0;
    i_rst     = 1'b1;
    i_valid   = 1'b0;
    i_sum     = 16'h0000;
    i_max_exp = 6'd0;
    i_zero    = 1'b0;
    i_ready   = 1'b1;
    checks    = 0;
    failures  = 0;
    number_ref = '0;
    test_reset();
    test_directed();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_number();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
